// File: rtl/sys_axi_pkg.sv
// ============================================================================
// Module  : sys_axi_pkg
// Brief   : Shared AXI widths, rresp encodings and the R-beat record.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_axi_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_DATA_WIDTH = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } r_beat_t;

endpackage

`default_nettype wire

// File: rtl/sys_axi_r_arbiter_if.sv
// ============================================================================
// Module  : sys_axi_r_arbiter_if
// Brief   : N packed R sources in, one merged R channel out, plus status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sys_axi_r_arbiter_if
  import sys_axi_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int ID_W   = AXI_ID_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH
);
  localparam int IDX_W = $clog2(N_SRC);

  logic [N_SRC*ID_W-1:0]   s_rid;
  logic [N_SRC*DATA_W-1:0] s_rdata;
  logic [N_SRC*2-1:0]      s_rresp;
  logic [N_SRC-1:0]        s_rlast;
  logic [N_SRC-1:0]        s_rvalid;
  logic [N_SRC-1:0]        s_rready;
  logic [ID_W-1:0]         m_rid;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;
  logic                    m_rvalid;
  logic                    m_rready;
  logic                    busy;
  logic [IDX_W-1:0]        cur_grant;

  // Arbiter side
  modport slave (
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, m_rready,
    output s_rready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, busy, cur_grant
  );

  // Environment side: drives the sources and the upstream ready
  modport master (
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, m_rready,
    input  s_rready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, busy, cur_grant
  );

endinterface

`default_nettype wire

// File: rtl/sys_rr_pick.sv
// ============================================================================
// Module  : sys_rr_pick
// Brief   : First set request at or after ptr (wrapping), as one-hot and index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so ptr+k never overflows before the modulo-N fold
  logic [IDX_W:0] w_pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N)) begin
        w_pos = w_pos - (IDX_W+1)'(N);
      end
      if (!any && req[w_pos[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = w_pos[IDX_W-1:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_axi_r_arbiter.sv
// ============================================================================
// Module  : sys_axi_r_arbiter
// Brief   : Burst-locked round-robin merge of N AXI R channels into one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_axi_r_arbiter
  import sys_axi_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int ID_W   = AXI_ID_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sys_axi_r_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_SRC-1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]   w_sel, w_pick_idx;
  logic [N_SRC-1:0]   w_pick_gnt, w_lock_oh;
  logic               w_pick_any, w_mvalid, w_mlast, w_hs;

  sys_rr_pick #(.N(N_SRC)) u_pick (
    .req (bus.s_rvalid),
    .ptr (r_rr_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Selection never looks at m_rready, so there is no ready->valid loop
  always_comb begin
    w_sel        = r_grant;
    w_lock_oh    = '0;
    w_mvalid     = 1'b0;
    w_mlast      = 1'b0;
    bus.m_rid    = '0;
    bus.m_rdata  = '0;
    bus.m_rresp  = RESP_OKAY;
    if (rst) begin
      w_sel = '0;
    end else if (r_state == ST_IDLE && w_pick_any) begin
      w_sel = w_pick_idx;
    end
    for (int i = 0; i < N_SRC; i++) begin
      w_lock_oh[i] = (r_grant == IDX_W'(i));
      if (w_sel == IDX_W'(i)) begin
        bus.m_rid   = bus.s_rid[i*ID_W +: ID_W];
        bus.m_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
        bus.m_rresp = bus.s_rresp[i*2 +: 2];
        w_mlast     = bus.s_rlast[i];
        w_mvalid    = bus.s_rvalid[i] & ~rst;
      end
    end
  end

  // Lock on a non-final beat; release and advance the pointer on the final one
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_hs) begin
      if (w_mlast) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = (w_sel == c_last_idx) ? '0 : w_sel + 1'b1;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_grant_nxt = w_sel;
      end
    end
  end

  assign w_hs          = w_mvalid & bus.m_rready;
  assign bus.m_rvalid  = w_mvalid;
  assign bus.m_rlast   = w_mlast;
  assign bus.s_rready  = rst ? '0 :
                         (((r_state == ST_LOCKED) ? w_lock_oh : w_pick_gnt) & {N_SRC{bus.m_rready}});
  assign bus.busy      = (r_state == ST_LOCKED) & ~rst;
  assign bus.cur_grant = w_sel;

endmodule

`default_nettype wire
